replicacao_pixel: RTL and testbench

Sequential nearest-neighbour upscaler: reads an 8-bit grayscale image of LARGURA×ALTURA from a source frame memory and writes an image of (LARGURA·FATOR)×(ALTURA·FATOR) to a destination frame memory, replicating each source pixel into a FATOR×FATOR block. It is the inverse of the decimation stage in the image pipeline. Both memories are raster-order, one byte per pixel. After a start pulse the block streams one output pixel per clock and then signals completion.

---
 rtl/replicacao_pixel.sv | 162 ++++++++++++++++
 tb/tb_replicacao_pixel.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/replicacao_pixel.sv
// rtl/replicacao_pixel.sv - nearest-neighbour pixel replication upscaler
//
// Reads a LARGURA x ALTURA 8-bit raster image from a synchronous-read source
// memory. Writes a (LARGURA*FATOR) x (ALTURA*FATOR) image in which every source
// pixel becomes a FATOR x FATOR block. One output pixel is produced per clock.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   iniciar      start request, accepted only while idle
//   end_leitura  source read address (registered)
//   dado_leitura source data, valid one cycle after end_leitura
//   end_escrita  destination write address (registered)
//   dado_escrita destination write data (registered)
//   escrita_en   destination write strobe
//   ocupado      high while a frame is in progress
//   pronto       one-cycle completion pulse
module replicacao_pixel #(
    parameter int LARGURA    = 40,
    parameter int ALTURA     = 30,
    parameter int FATOR      = 2,
    parameter int NEW_LARG   = LARGURA * FATOR,
    parameter int NEW_ALTURA = ALTURA * FATOR,
    localparam int AW_IN  = (LARGURA * ALTURA > 1) ? $clog2(LARGURA * ALTURA) : 1,
    localparam int AW_OUT = (NEW_LARG * NEW_ALTURA > 1) ? $clog2(NEW_LARG * NEW_ALTURA) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iniciar,
    output logic [AW_IN-1:0]  end_leitura,
    input  logic [7:0]        dado_leitura,
    output logic [AW_OUT-1:0] end_escrita,
    output logic [7:0]        dado_escrita,
    output logic              escrita_en,
    output logic              ocupado,
    output logic              pronto
);

    localparam int FW = (FATOR > 1) ? $clog2(FATOR) : 1;

    localparam logic [FW-1:0]    F_ULT   = FW'(FATOR - 1);
    localparam logic [AW_IN-1:0] L_ULT   = AW_IN'(LARGURA - 1);
    localparam logic [AW_IN-1:0] A_ULT   = AW_IN'(ALTURA - 1);
    localparam logic [AW_IN-1:0] L_PASSO = AW_IN'(LARGURA);

    typedef enum logic [1:0] {OCIOSO, VARRE, DRENO, FIM} estado_t;

    estado_t estado, prox;

    // sc/sl count replicas of the current source pixel/row; col/row walk the
    // source image; base is the start address of the current source row.
    logic [FW-1:0]     sc, sl, n_sc, n_sl;
    logic [AW_IN-1:0]  col, row, base, n_col, n_row, n_base;
    logic [AW_OUT-1:0] windex;
    logic              valido2;
    logic              ultimo;

    // The pixel currently being read is the final output pixel of the frame.
    assign ultimo = (sc == F_ULT) && (col == L_ULT) && (sl == F_ULT) && (row == A_ULT);

    always_comb begin
        n_sc   = sc;
        n_col  = col;
        n_sl   = sl;
        n_row  = row;
        n_base = base;
        if (sc == F_ULT) begin
            n_sc = '0;
            if (col == L_ULT) begin
                n_col = '0;
                if (sl == F_ULT) begin
                    n_sl   = '0;
                    n_row  = row + 1'b1;
                    n_base = base + L_PASSO;
                end else begin
                    // Same source row is re-read for the next output row.
                    n_sl = sl + 1'b1;
                end
            end else begin
                n_col = col + 1'b1;
            end
        end else begin
            n_sc = sc + 1'b1;
        end
    end

    always_comb begin
        prox = estado;
        unique case (estado)
            OCIOSO: if (iniciar) prox = VARRE;
            VARRE:  if (ultimo) prox = DRENO;
            DRENO:  if (!valido2) prox = FIM;
            FIM:    prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado       <= OCIOSO;
            sc           <= '0;
            sl           <= '0;
            col          <= '0;
            row          <= '0;
            base         <= '0;
            windex       <= '0;
            valido2      <= 1'b0;
            end_leitura  <= '0;
            end_escrita  <= '0;
            dado_escrita <= '0;
            escrita_en   <= 1'b0;
            ocupado      <= 1'b0;
            pronto       <= 1'b0;
        end else begin
            estado  <= prox;
            ocupado <= (prox == VARRE) || (prox == DRENO);
            pronto  <= (prox == FIM);

            // Stage 2: the memory returns data one cycle after the address
            // register, so valido2 marks cycles where dado_leitura is live.
            valido2      <= (estado == VARRE);
            escrita_en   <= valido2;
            dado_escrita <= valido2 ? dado_leitura : 8'h00;
            if (valido2) begin
                end_escrita <= windex;
                windex      <= windex + 1'b1;
            end else if (estado == FIM) begin
                end_escrita <= '0;
                windex      <= '0;
            end

            unique case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        sc          <= '0;
                        sl          <= '0;
                        col         <= '0;
                        row         <= '0;
                        base        <= '0;
                        windex      <= '0;
                        end_leitura <= '0;
                    end
                end
                VARRE: begin
                    if (!ultimo) begin
                        sc          <= n_sc;
                        sl          <= n_sl;
                        col         <= n_col;
                        row         <= n_row;
                        base        <= n_base;
                        end_leitura <= n_base + n_col;
                    end
                end
                DRENO: begin
                end
                FIM: begin
                    end_leitura <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_replicacao_pixel.sv
// tb/tb_replicacao_pixel.sv - directed self-checking bench for replicacao_pixel
module tb_replicacao_pixel;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ini = 1'b0;
    int   sel = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // DUT A: 4x2, F=2
    logic [2:0] a_el; logic [4:0] a_ee; logic [7:0] a_rd, a_de; logic a_we, a_oc, a_pr;
    // DUT B: 4x2, F=1
    logic [2:0] b_el; logic [2:0] b_ee; logic [7:0] b_rd, b_de; logic b_we, b_oc, b_pr;
    // DUT C: 2x2, F=3
    logic [1:0] c_el; logic [5:0] c_ee; logic [7:0] c_rd, c_de; logic c_we, c_oc, c_pr;
    // DUT D: 1x1, F=2
    logic [0:0] d_el; logic [1:0] d_ee; logic [7:0] d_rd, d_de; logic d_we, d_oc, d_pr;

    logic [7:0] mem_a [8];
    logic [7:0] mem_b [8];
    logic [7:0] mem_c [4];
    logic [7:0] mem_d [2];

    always @(posedge clk) begin
        a_rd <= mem_a[a_el];
        b_rd <= mem_b[b_el];
        c_rd <= mem_c[c_el];
        d_rd <= mem_d[d_el];
    end

    replicacao_pixel #(.LARGURA(4), .ALTURA(2), .FATOR(2)) u_a (
        .clk(clk), .reset(rst), .iniciar(ini && sel == 0), .end_leitura(a_el),
        .dado_leitura(a_rd), .end_escrita(a_ee), .dado_escrita(a_de),
        .escrita_en(a_we), .ocupado(a_oc), .pronto(a_pr));

    replicacao_pixel #(.LARGURA(4), .ALTURA(2), .FATOR(1)) u_b (
        .clk(clk), .reset(rst), .iniciar(ini && sel == 1), .end_leitura(b_el),
        .dado_leitura(b_rd), .end_escrita(b_ee), .dado_escrita(b_de),
        .escrita_en(b_we), .ocupado(b_oc), .pronto(b_pr));

    replicacao_pixel #(.LARGURA(2), .ALTURA(2), .FATOR(3)) u_c (
        .clk(clk), .reset(rst), .iniciar(ini && sel == 2), .end_leitura(c_el),
        .dado_leitura(c_rd), .end_escrita(c_ee), .dado_escrita(c_de),
        .escrita_en(c_we), .ocupado(c_oc), .pronto(c_pr));

    replicacao_pixel #(.LARGURA(1), .ALTURA(1), .FATOR(2)) u_d (
        .clk(clk), .reset(rst), .iniciar(ini && sel == 3), .end_leitura(d_el),
        .dado_leitura(d_rd), .end_escrita(d_ee), .dado_escrita(d_de),
        .escrita_en(d_we), .ocupado(d_oc), .pronto(d_pr));

    logic [31:0] o_el, o_ee, o_de, o_we, o_oc, o_pr;

    always_comb begin
        o_el = '0; o_ee = '0; o_de = '0; o_we = '0; o_oc = '0; o_pr = '0;
        case (sel)
            0: begin o_el = 32'(a_el); o_ee = 32'(a_ee); o_de = 32'(a_de);
                     o_we = 32'(a_we); o_oc = 32'(a_oc); o_pr = 32'(a_pr); end
            1: begin o_el = 32'(b_el); o_ee = 32'(b_ee); o_de = 32'(b_de);
                     o_we = 32'(b_we); o_oc = 32'(b_oc); o_pr = 32'(b_pr); end
            2: begin o_el = 32'(c_el); o_ee = 32'(c_ee); o_de = 32'(c_de);
                     o_we = 32'(c_we); o_oc = 32'(c_oc); o_pr = 32'(c_pr); end
            default: begin o_el = 32'(d_el); o_ee = 32'(d_ee); o_de = 32'(d_de);
                     o_we = 32'(d_we); o_oc = 32'(d_oc); o_pr = 32'(d_pr); end
        endcase
    end

    int exp_dat [64];
    int exp_rd  [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Called mid-cycle while the selected DUT is idle; iniciar is sampled at the
    // next edge (E0). Checks cycles 1..n+4 against exp_dat/exp_rd.
    task automatic run_frame(input int n, input bit hold);
        ini = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= n + 4; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) ini = 1'b0;
            chk($sformatf("ocupado c%0d", c), o_oc, (c <= n + 2) ? 1 : 0);
            chk($sformatf("escrita_en c%0d", c), o_we, (c >= 3 && c <= n + 2) ? 1 : 0);
            chk($sformatf("pronto c%0d", c), o_pr, (c == n + 3) ? 1 : 0);
            if (c <= n)
                chk($sformatf("end_leitura c%0d", c), o_el, exp_rd[c-1]);
            if (c >= 3 && c <= n + 2) begin
                chk($sformatf("end_escrita c%0d", c), o_ee, c - 3);
                chk($sformatf("dado_escrita c%0d", c), o_de, exp_dat[c-3]);
            end
            if (c == n + 4) begin
                chk("idle end_leitura", o_el, 0);
                chk("idle end_escrita", o_ee, 0);
                chk("idle dado_escrita", o_de, 0);
            end
        end
    endtask

    task automatic load_a;
        int r0 [8];
        int r1 [8];
        r0 = '{8'h10, 8'h10, 8'h11, 8'h11, 8'h12, 8'h12, 8'h13, 8'h13};
        r1 = '{8'h14, 8'h14, 8'h15, 8'h15, 8'h16, 8'h16, 8'h17, 8'h17};
        for (int i = 0; i < 32; i++) begin
            exp_dat[i] = ((i / 8) < 2) ? r0[i % 8] : r1[i % 8];
            exp_rd[i]  = exp_dat[i] - 8'h10;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem_a[i] = 8'(8'h10 + i);
            mem_b[i] = 8'(8'hA0 + i);
        end
        mem_c = '{8'd1, 8'd2, 8'd3, 8'd4};
        mem_d = '{8'h5A, 8'h00};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst end_leitura", o_el, 0);
        chk("rst end_escrita", o_ee, 0);
        chk("rst dado_escrita", o_de, 0);
        chk("rst escrita_en", o_we, 0);
        chk("rst ocupado", o_oc, 0);
        chk("rst pronto", o_pr, 0);
        rst = 1'b0;
        @(negedge clk);

        // 4x2, F=2
        sel = 0;
        load_a();
        run_frame(32, 1'b0);

        // 4x2, F=1: plain copy
        sel = 1;
        for (int i = 0; i < 8; i++) begin
            exp_dat[i] = 8'hA0 + i;
            exp_rd[i]  = i;
        end
        run_frame(8, 1'b0);

        // 2x2, F=3
        sel = 2;
        begin
            int r0 [6];
            int r1 [6];
            r0 = '{1, 1, 1, 2, 2, 2};
            r1 = '{3, 3, 3, 4, 4, 4};
            for (int i = 0; i < 36; i++) begin
                exp_dat[i] = ((i / 6) < 3) ? r0[i % 6] : r1[i % 6];
                exp_rd[i]  = exp_dat[i] - 1;
            end
        end
        run_frame(36, 1'b0);

        // 1x1, F=2
        sel = 3;
        for (int i = 0; i < 4; i++) begin
            exp_dat[i] = 8'h5A;
            exp_rd[i]  = 0;
        end
        run_frame(4, 1'b0);

        // iniciar held high: back-to-back frames restart only from idle
        sel = 0;
        load_a();
        run_frame(32, 1'b1);
        run_frame(32, 1'b1);
        ini = 1'b0;
        @(negedge clk);
        chk("held stop ocupado", o_oc, 0);

        // Asynchronous reset mid-frame, during cycle 10
        ini = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ini = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre-reset escrita_en", o_we, 1);
        chk("pre-reset end_escrita", o_ee, 7);
        #1 rst = 1'b1;
        #1;
        chk("async end_leitura", o_el, 0);
        chk("async end_escrita", o_ee, 0);
        chk("async dado_escrita", o_de, 0);
        chk("async escrita_en", o_we, 0);
        chk("async ocupado", o_oc, 0);
        chk("async pronto", o_pr, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("post-reset escrita_en", o_we, 0);
            chk("post-reset pronto", o_pr, 0);
        end
        run_frame(32, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
